// File: rtl/bch_31_pkg.sv
// ============================================================================
// Module  : bch_31_pkg
// Brief   : GF(2^5) arithmetic (x^5+x^2+1), BCH(31,21) constants, decoder FSM
//           state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bch_31_pkg;

    localparam int         N      = 31;
    localparam logic [4:0] ALPHA  = 5'b00010;
    localparam logic [4:0] ALPHA3 = 5'b01000;

    typedef logic [2:0] bch_dec_state_t;
    localparam bch_dec_state_t ST_IDLE  = 3'd0;
    localparam bch_dec_state_t ST_SYND  = 3'd1;
    localparam bch_dec_state_t ST_KEY   = 3'd2;
    localparam bch_dec_state_t ST_CHIEN = 3'd3;
    localparam bch_dec_state_t ST_OUT   = 3'd4;

    // Shift-and-add multiply; x^5 folds back to x^2+1.
    function automatic logic [4:0] gf_mult(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] p;
        logic [4:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 5; i++) begin
            if (b[i]) p = p ^ t;
            t = t[4] ? ({t[3:0], 1'b0} ^ 5'b00101) : {t[3:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [4:0] gf_pow(input logic [4:0] a, input logic [4:0] e);
        logic [4:0] r;
        r = 5'b00001;
        for (int i = 4; i >= 0; i--) begin
            r = gf_mult(r, r);
            if (e[i]) r = gf_mult(r, a);
        end
        return r;
    endfunction

    // x^30 = alpha^(31 - log x) for nonzero x, and maps 0 to 0.
    function automatic logic [4:0] gf_inv(input logic [4:0] x);
        return gf_pow(x, 5'd30);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bch_31_chien.sv
// ============================================================================
// Module  : bch_31_chien
// Brief   : Combinational Chien search; bit i flags Lambda(alpha^-i) == 0 for
//           Lambda(x) = 1 + l1*x + l2*x^2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bch_31_chien
    import bch_31_pkg::*;
(
    input  logic [4:0]  i_lambda1,
    input  logic [4:0]  i_lambda2,
    output logic [30:0] o_error_vector
);

    for (genvar i = 0; i < N; i++) begin : g_pos
        localparam logic [4:0] c_xinv  = gf_pow(ALPHA, 5'((N - i) % N));
        localparam logic [4:0] c_xinv2 = gf_mult(c_xinv, c_xinv);
        logic [4:0] w_eval;
        assign w_eval = 5'b00001 ^ gf_mult(i_lambda1, c_xinv) ^ gf_mult(i_lambda2, c_xinv2);
        assign o_error_vector[i] = (w_eval == 5'b00000);
    end

endmodule

`default_nettype wire

// File: rtl/bch_31_synd_serial.sv
// ============================================================================
// Module  : bch_31_synd_serial
// Brief   : Serial Horner evaluation of S1 = r(alpha) and S3 = r(alpha^3),
//           MSB coefficient first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bch_31_synd_serial
    import bch_31_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [4:0] o_s1,
    output logic [4:0] o_s3
);

    logic [4:0] r_s1;
    logic [4:0] r_s3;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_s1 <= '0;
            r_s3 <= '0;
        end else if (i_en) begin
            r_s1 <= gf_mult(r_s1, ALPHA)  ^ {4'b0, i_bit};
            r_s3 <= gf_mult(r_s3, ALPHA3) ^ {4'b0, i_bit};
        end
    end

    assign o_s1 = r_s1;
    assign o_s3 = r_s3;

endmodule

`default_nettype wire

// File: rtl/bch_31_dec_ctrl.sv
// ============================================================================
// Module  : bch_31_dec_ctrl
// Brief   : BCH(31,21) t=2 decoder sequencer: serial syndromes, closed-form
//           key equation, Chien search, held output with handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bch_31_dec_ctrl
    import bch_31_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] out_data,
    output logic [1:0]  out_nerr,
    output logic        out_uncorr,
    output logic        busy
);

    bch_dec_state_t r_state;
    logic [30:0]    r_word;
    logic [30:0]    r_ev;
    logic [4:0]     r_cnt;
    logic [4:0]     r_lam1;
    logic [4:0]     r_lam2;
    logic [1:0]     r_deg;
    logic [1:0]     r_nerr;
    logic           r_uncorr;

    logic           w_accept;
    logic [4:0]     w_s1;
    logic [4:0]     w_s3;
    logic [4:0]     w_s1_sq;
    logic [4:0]     w_s1_cube;
    logic [4:0]     w_lam2;
    logic [30:0]    w_ev;
    logic [4:0]     w_wt;
    logic           w_fail;

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = ~in_ready;
    assign out_valid = (r_state == ST_OUT);
    assign w_accept  = in_valid & in_ready;

    assign out_data   = r_uncorr ? r_word : (r_word ^ r_ev);
    assign out_nerr   = r_nerr;
    assign out_uncorr = r_uncorr;

    bch_31_synd_serial u_synd (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_en    (r_state == ST_SYND),
        .i_bit   (r_word[r_cnt]),
        .o_s1    (w_s1),
        .o_s3    (w_s3)
    );

    bch_31_chien u_chien (
        .i_lambda1      (r_lam1),
        .i_lambda2      (r_lam2),
        .o_error_vector (w_ev)
    );

    // PGZ closed form for t=2: lambda2 = S3/S1 + S1^2
    assign w_s1_sq   = gf_mult(w_s1, w_s1);
    assign w_s1_cube = gf_mult(w_s1_sq, w_s1);
    assign w_lam2    = gf_mult(w_s3, gf_inv(w_s1)) ^ w_s1_sq;

    always_comb begin
        w_wt = '0;
        for (int i = 0; i < N; i++) begin
            w_wt = w_wt + {4'b0, w_ev[i]};
        end
    end

    // Root count must match the locator degree, otherwise >2 errors occurred.
    assign w_fail = r_uncorr | (w_wt != {3'b000, r_deg});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_word   <= '0;
            r_ev     <= '0;
            r_cnt    <= '0;
            r_lam1   <= '0;
            r_lam2   <= '0;
            r_deg    <= '0;
            r_nerr   <= '0;
            r_uncorr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_word   <= in_data;
                        r_cnt    <= 5'd30;
                        r_ev     <= '0;
                        r_lam1   <= '0;
                        r_lam2   <= '0;
                        r_deg    <= '0;
                        r_nerr   <= '0;
                        r_uncorr <= 1'b0;
                        r_state  <= ST_SYND;
                    end
                end
                ST_SYND: begin
                    if (r_cnt == 5'd0) r_state <= ST_KEY;
                    else               r_cnt   <= r_cnt - 5'd1;
                end
                ST_KEY: begin
                    if (w_s1 == 5'd0) begin
                        r_lam1   <= '0;
                        r_lam2   <= '0;
                        r_deg    <= 2'd0;
                        r_uncorr <= (w_s3 != 5'd0);
                    end else if (w_s3 == w_s1_cube) begin
                        r_lam1 <= w_s1;
                        r_lam2 <= '0;
                        r_deg  <= 2'd1;
                    end else begin
                        r_lam1 <= w_s1;
                        r_lam2 <= w_lam2;
                        r_deg  <= 2'd2;
                    end
                    r_state <= ST_CHIEN;
                end
                ST_CHIEN: begin
                    r_ev     <= w_ev;
                    r_uncorr <= w_fail;
                    r_nerr   <= w_fail ? 2'd0 : w_wt[1:0];
                    r_state  <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
